pic_interrupt_sequencer: RTL and testbench



---
 rtl/pic_pkg.sv | 25 ++
 rtl/pic_priority_resolver.sv | 25 ++
 rtl/pic_interrupt_sequencer.sv | 177 +++++++++++++++++
 tb/tb_pic_interrupt_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC interrupt sequencer.
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK1 = 2'd2,
    ACK2 = 2'd3
  } state_t;

  // OCW2 {R,SL,EOI} command codes
  localparam logic [2:0] NSEOI     = 3'b001;
  localparam logic [2:0] SEOI      = 3'b011;
  localparam logic [2:0] ROT_NSEOI = 3'b101;
  localparam logic [2:0] ROT_SEOI  = 3'b111;
  localparam logic [2:0] SETPRI    = 3'b110;

  localparam int unsigned DEFAULT_SPURIOUS_LEVEL = 7;

  // Priority rank of a level relative to the rotating base (0 = highest)
  function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] base);
    return 3'(lvl - base);
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Finds the highest-priority set request bit, starting from base and wrapping mod 8.
module pic_priority_resolver (
  input  logic [7:0] req,
  input  logic [2:0] base,
  output logic       valid,
  output logic [2:0] level
);

  logic [2:0] idx;

  // Scan from lowest priority up so the highest-priority hit is the last assignment
  always_comb begin
    valid = 1'b0;
    level = 3'd0;
    idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = 3'(base + 3'(i));
      if (req[idx]) begin
        valid = 1'b1;
        level = idx;
      end
    end
  end

endmodule

// File: rtl/pic_interrupt_sequencer.sv
// PIC interrupt sequencer: priority resolution, 8086 INTA sequence, ISR/EOI handling.
// Optional rotating priority is enabled with `define PIC_ROTATE_EN.
module pic_interrupt_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned SPURIOUS_LEVEL = DEFAULT_SPURIOUS_LEVEL,
  parameter int unsigned NUM_IR         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic [7:0]        icw2,
  input  logic              aeoi,
  input  logic [NUM_IR-1:0] imr,
  input  logic [7:0]        ocw2,
  input  logic              ocw2_stb,
  input  logic [NUM_IR-1:0] irr,
  input  logic              inta_n,
  output logic              int_out,
  output logic [NUM_IR-1:0] irr_clr,
  output logic [NUM_IR-1:0] isr,
  output logic [7:0]        vector,
  output logic              vector_oe
);

  state_t            state, state_n;
  logic              inta_q;
  logic              fall, rise;
  logic [2:0]        base, base_n;
  logic [2:0]        lvl, lvl_n;
  logic              spur, spur_n;
  logic              int_n;
  logic [NUM_IR-1:0] irr_clr_n, isr_n;
  logic [7:0]        vector_n;
  logic              oe_n;
  logic [NUM_IR-1:0] cand;
  logic              win_valid, isr_valid, win_ok;
  logic [2:0]        win_level, isr_level;
  logic              unused_bits;

  assign unused_bits = ^{icw2[2:0], ocw2[7], ocw2[4:3]};

  assign fall = inta_q & ~inta_n;
  assign rise = ~inta_q & inta_n;
  assign cand = irr & ~imr;

  pic_priority_resolver u_win (
    .req  (cand),
    .base (base),
    .valid(win_valid),
    .level(win_level)
  );

  pic_priority_resolver u_isr (
    .req  (isr),
    .base (base),
    .valid(isr_valid),
    .level(isr_level)
  );

  // A request only wins if it outranks everything currently in service
  assign win_ok = init_done & win_valid &
                  (~isr_valid | (rank(win_level, base) < rank(isr_level, base)));

  // Next-state, OCW2 decode and registered-output next values
  always_comb begin
    state_n   = state;
    base_n    = base;
    lvl_n     = lvl;
    spur_n    = spur;
    irr_clr_n = '0;
    isr_n     = isr;
    vector_n  = vector;
    oe_n      = vector_oe;

    // EOI handling precedes the ACK1 set so a same-bit set wins
    if (ocw2_stb) begin
      case (ocw2[7:5])
        NSEOI, ROT_NSEOI: begin
          if (isr_valid) begin
            isr_n[isr_level] = 1'b0;
`ifdef PIC_ROTATE_EN
            if (ocw2[7]) base_n = 3'(isr_level + 3'd1);
`endif
          end
        end
        SEOI, ROT_SEOI: begin
          isr_n[ocw2[2:0]] = 1'b0;
`ifdef PIC_ROTATE_EN
          if (ocw2[7]) base_n = 3'(ocw2[2:0] + 3'd1);
`endif
        end
        SETPRI: begin
`ifdef PIC_ROTATE_EN
          base_n = 3'(ocw2[2:0] + 3'd1);
`endif
        end
        default: ;
      endcase
    end

    case (state)
      IDLE: begin
        if (fall) begin
          state_n = ACK1;
          lvl_n   = 3'(SPURIOUS_LEVEL);
          spur_n  = 1'b1;
        end else if (win_ok) begin
          state_n = PEND;
        end
      end
      PEND: begin
        if (fall) begin
          state_n = ACK1;
          if (win_ok) begin
            lvl_n                = win_level;
            spur_n               = 1'b0;
            isr_n[win_level]     = 1'b1;
            irr_clr_n[win_level] = 1'b1;
          end else begin
            lvl_n  = 3'(SPURIOUS_LEVEL);
            spur_n = 1'b1;
          end
        end
      end
      ACK1: begin
        if (fall) begin
          state_n  = ACK2;
          vector_n = {icw2[7:3], lvl};
          oe_n     = 1'b1;
        end
      end
      ACK2: begin
        if (rise) begin
          state_n = IDLE;
          oe_n    = 1'b0;
          if (aeoi && !spur) isr_n[lvl] = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    int_n = win_ok & ((state_n == IDLE) | (state_n == PEND));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Registered outputs and sequencing context
  always_ff @(posedge clk) begin
    if (rst) begin
      inta_q    <= 1'b1;
      base      <= 3'd0;
      lvl       <= 3'd0;
      spur      <= 1'b0;
      int_out   <= 1'b0;
      irr_clr   <= '0;
      isr       <= '0;
      vector    <= 8'd0;
      vector_oe <= 1'b0;
    end else begin
      inta_q    <= inta_n;
      base      <= base_n;
      lvl       <= lvl_n;
      spur      <= spur_n;
      int_out   <= int_n;
      irr_clr   <= irr_clr_n;
      isr       <= isr_n;
      vector    <= vector_n;
      vector_oe <= oe_n;
    end
  end

endmodule

// File: tb/tb_pic_interrupt_sequencer.sv
// Directed self-checking bench for pic_interrupt_sequencer.
module tb_pic_interrupt_sequencer;

  logic       clk, rst, init_done, aeoi, ocw2_stb, inta_n;
  logic [7:0] icw2, imr, ocw2, irr;
  logic       int_out, vector_oe;
  logic [7:0] irr_clr, isr, vector;

  int errors = 0;
  int checks = 0;

  logic [7:0] clr1, isr1, vec;
  logic       oe2, oe_end;

  pic_interrupt_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .init_done(init_done),
    .icw2     (icw2),
    .aeoi     (aeoi),
    .imr      (imr),
    .ocw2     (ocw2),
    .ocw2_stb (ocw2_stb),
    .irr      (irr),
    .inta_n   (inta_n),
    .int_out  (int_out),
    .irr_clr  (irr_clr),
    .isr      (isr),
    .vector   (vector),
    .vector_oe(vector_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full two-pulse acknowledge; the bench plays the IRR and drops the cleared bit
  task automatic ack;
    inta_n = 1'b0; tick;
    clr1 = irr_clr; isr1 = isr;
    irr = irr & ~irr_clr;
    inta_n = 1'b1; tick;
    inta_n = 1'b0; tick;
    vec = vector; oe2 = vector_oe;
    inta_n = 1'b1; tick;
    oe_end = vector_oe;
  endtask

  task automatic send_ocw2(input logic [7:0] val);
    ocw2 = val; ocw2_stb = 1'b1; tick;
    ocw2_stb = 1'b0;
  endtask

  initial begin
    rst = 1'b1; init_done = 1'b0; aeoi = 1'b0; ocw2_stb = 1'b0; inta_n = 1'b1;
    icw2 = 8'h40; imr = 8'h00; ocw2 = 8'h00; irr = 8'h00;
    tick; tick;
    rst = 1'b0;
    check("rst_int", {7'd0, int_out}, 8'h00);
    check("rst_isr", isr, 8'h00);
    check("rst_clr", irr_clr, 8'h00);
    check("rst_vec", vector, 8'h00);
    check("rst_oe", {7'd0, vector_oe}, 8'h00);

    // Basic acknowledge of IR3
    init_done = 1'b1; irr = 8'h08; tick;
    check("t1_int", {7'd0, int_out}, 8'h01);
    ack;
    check("t1_clr", clr1, 8'h08);
    check("t1_isr1", isr1, 8'h08);
    check("t1_vec", vec, 8'h43);
    check("t1_oe", {7'd0, oe2}, 8'h01);
    check("t1_oe_end", {7'd0, oe_end}, 8'h00);
    check("t1_isr", isr, 8'h08);

    // Nesting: IR1 preempts IR3, IR5 blocked until both EOIs
    irr = 8'h02; tick;
    check("t2_int", {7'd0, int_out}, 8'h01);
    ack;
    check("t2_vec", vec, 8'h41);
    check("t2_isr", isr, 8'h0A);
    irr = 8'h20; tick; tick;
    check("t2_blk", {7'd0, int_out}, 8'h00);
    send_ocw2(8'h20);
    check("t2_eoi1", isr, 8'h08);
    tick;
    check("t2_blk2", {7'd0, int_out}, 8'h00);
    send_ocw2(8'h20);
    check("t2_eoi2", isr, 8'h00);
    tick;
    check("t2_int5", {7'd0, int_out}, 8'h01);
    ack;
    check("t2_vec5", vec, 8'h45);
    check("t2_isr5", isr, 8'h20);
    send_ocw2(8'h65);
    check("t2_seoi", isr, 8'h00);

    // Request withdrawn before INTA -> spurious
    irr = 8'h04; tick;
    check("t3_int", {7'd0, int_out}, 8'h01);
    irr = 8'h00;
    ack;
    check("t3_clr", clr1, 8'h00);
    check("t3_isr1", isr1, 8'h00);
    check("t3_vec", vec, 8'h47);
    check("t3_isr", isr, 8'h00);

    // Automatic EOI
    aeoi = 1'b1; irr = 8'h01; tick;
    ack;
    check("t4_isr1", isr1, 8'h01);
    check("t4_vec", vec, 8'h40);
    check("t4_isr", isr, 8'h00);
    aeoi = 1'b0;

    // Specific EOI, EOI no-op, full mask
    irr = 8'h08; tick; ack;
    irr = 8'h02; tick; ack;
    check("t5_isr", isr, 8'h0A);
    send_ocw2(8'h63);
    check("t5_seoi", isr, 8'h02);
    send_ocw2(8'h20);
    check("t5_nseoi", isr, 8'h00);
    send_ocw2(8'h20);
    check("t5_noop", isr, 8'h00);
    imr = 8'hFF; irr = 8'hFF; tick; tick;
    check("t5_mask", {7'd0, int_out}, 8'h00);
    imr = 8'h00; irr = 8'h00; tick;

    // init_done low suppresses INT
    init_done = 1'b0; irr = 8'h01; tick; tick;
    check("t6_init0", {7'd0, int_out}, 8'h00);
    init_done = 1'b1; tick;
    check("t6_init1", {7'd0, int_out}, 8'h01);
    ack;
    check("t6_vec", vec, 8'h40);
    send_ocw2(8'h20);
    check("t6_isr", isr, 8'h00);

    // INTA with nothing pending
    irr = 8'h00; tick;
    ack;
    check("t7_clr", clr1, 8'h00);
    check("t7_vec", vec, 8'h47);
    check("t7_isr", isr, 8'h00);

    // Priority set / rotation
    icw2 = 8'h48; irr = 8'h81;
    send_ocw2(8'hC6);
    tick;
    check("t8_int", {7'd0, int_out}, 8'h01);
    ack;
`ifdef PIC_ROTATE_EN
    check("t8_vec7", vec, 8'h4F);
    check("t8_isr7", isr, 8'h80);
    tick;
    check("t8_blk", {7'd0, int_out}, 8'h00);
    send_ocw2(8'hA0);
    check("t8_rot", isr, 8'h00);
    tick;
    check("t8_int0", {7'd0, int_out}, 8'h01);
    ack;
    check("t8_vec0", vec, 8'h48);
    send_ocw2(8'h20);
    check("t8_clr", isr, 8'h00);
`else
    check("t8_vec0", vec, 8'h48);
    check("t8_isr0", isr, 8'h01);
    tick;
    check("t8_blk", {7'd0, int_out}, 8'h00);
    send_ocw2(8'hA0);
    check("t8_a0", isr, 8'h00);
    tick;
    check("t8_int7", {7'd0, int_out}, 8'h01);
    ack;
    check("t8_vec7", vec, 8'h4F);
    send_ocw2(8'h20);
    check("t8_clr", isr, 8'h00);
`endif

    // Reset during ACK1
    irr = 8'h04; tick;
    inta_n = 1'b0; tick;
    check("t9_isr", isr, 8'h04);
    rst = 1'b1; inta_n = 1'b1; irr = 8'h00; tick;
    check("t9_r_int", {7'd0, int_out}, 8'h00);
    check("t9_r_isr", isr, 8'h00);
    check("t9_r_clr", irr_clr, 8'h00);
    check("t9_r_vec", vector, 8'h00);
    check("t9_r_oe", {7'd0, vector_oe}, 8'h00);
    rst = 1'b0;

    // Reset on the acknowledging edge suppresses the irr_clr pulse
    irr = 8'h02; tick;
    check("t10_int", {7'd0, int_out}, 8'h01);
    inta_n = 1'b0; rst = 1'b1; tick;
    check("t10_clr", irr_clr, 8'h00);
    check("t10_isr", isr, 8'h00);
    rst = 1'b0; inta_n = 1'b1; irr = 8'h00; tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
